// File: rtl/echo_mc.sv
// echo_mc: multi-channel echo with one shared multiplier and one shared delay-line memory
// Ports: clk/srst (sync, active high), enable_in (low = flush and idle), mode_in (0 feedback, 1 feedforward),
//   delay_in (delay in samples minus one), decay_in (signed Q1.15 gain), audio_in/audio_out (channel c at
//   [c*NBITS +: NBITS]), tick_out (sample strobe), valid_out (pulses when audio_out updates).
// Define ECHO_MC_SATURATE_EN to clamp the sum instead of wrapping it.
module echo_mc #(
  parameter int NBITS = 16,
  parameter int NCHAN = 2,
  parameter int DELAY_MAX_LENGTH = 4096,
  parameter int CLOCK_DIVIDER = 1134
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   enable_in,
  input  logic                   mode_in,
  input  logic [15:0]            delay_in,
  input  logic [15:0]            decay_in,
  input  logic [NCHAN*NBITS-1:0] audio_in,
  output logic [NCHAN*NBITS-1:0] audio_out,
  output logic                   tick_out,
  output logic                   valid_out
);
  localparam int AW = DELAY_MAX_LENGTH > 1 ? $clog2(DELAY_MAX_LENGTH) : 1;
  localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  localparam int DW = $clog2(CLOCK_DIVIDER);
  localparam logic [15:0] DMAX_M1 = 16'(DELAY_MAX_LENGTH - 1);
  localparam logic [CW-1:0] LAST = CW'(NCHAN - 1);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t r_state, w_next;
  logic [DW-1:0] r_cnt;
  logic [CW-1:0] r_ch;
  logic [AW-1:0] r_ptr, w_lm1;
  logic r_filled, r_mode, r_valid, w_tick, w_we, w_last;
  logic [15:0] r_delay, r_decay;
  logic [NCHAN*NBITS-1:0] r_audio, r_stage, w_out;
  logic [NBITS-1:0] r_mem [NCHAN*DELAY_MAX_LENGTH];
  logic signed [NBITS-1:0] r_rdata, w_x, w_d, w_y;
  logic signed [NBITS+15:0] w_p;
  logic signed [NBITS:0] w_e, w_s;
  logic [CW+AW-1:0] w_addr;
  assign w_tick = r_cnt == DW'(1);
  assign tick_out = w_tick;
  assign valid_out = r_valid;
  assign w_last = r_ch == LAST;
  // L-1 with the requested delay clamped to the memory depth
  assign w_lm1 = r_delay > DMAX_M1 ? DMAX_M1[AW-1:0] : r_delay[AW-1:0];
  // depth is a power of two, so c*DEPTH+ptr is a plain concatenation
  assign w_addr = {r_ch, r_ptr};
  assign w_x = r_audio[r_ch*NBITS +: NBITS];
  assign w_d = r_filled ? r_rdata : '0;
  assign w_p = $signed(r_decay) * w_d;
  assign w_e = (NBITS+1)'(w_p >>> 15);
  assign w_s = {w_x[NBITS-1], w_x} + w_e;
`ifdef ECHO_MC_SATURATE_EN
  assign w_y = (w_s[NBITS] != w_s[NBITS-1]) ? {w_s[NBITS], {(NBITS-1){~w_s[NBITS]}}} : w_s[NBITS-1:0];
`else
  assign w_y = w_s[NBITS-1:0];
`endif
  assign w_we = enable_in && r_state == WR;
  // audio_out is loaded with the last channel's result directly so every channel changes together with valid_out
  always_comb begin
    w_out = r_stage;
    w_out[(NCHAN-1)*NBITS +: NBITS] = w_y;
  end
  always_comb begin
    w_next = IDLE;
    if (enable_in)
      w_next = r_state == IDLE ? (w_tick ? RD : IDLE) :
               r_state == RD   ? WR :
               r_state == WR   ? (w_last ? DONE : RD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= r_mode ? w_x : w_y;
    if (r_state == RD) r_rdata <= r_mem[w_addr];
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_ch <= '0;
      r_ptr <= '0;
      r_filled <= 1'b0;
      r_mode <= 1'b0;
      r_delay <= '0;
      r_decay <= '0;
      r_audio <= '0;
      r_stage <= '0;
      r_valid <= 1'b0;
      audio_out <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (!enable_in || r_cnt == DW'(CLOCK_DIVIDER - 1)) ? '0 : r_cnt + 1'b1;
      r_valid <= w_we && w_last;
      if (w_tick) begin
        r_audio <= audio_in;
        r_delay <= delay_in;
        r_decay <= decay_in;
        r_mode <= mode_in;
        r_ch <= '0;
      end
      if (w_we) begin
        r_stage[r_ch*NBITS +: NBITS] <= w_y;
        r_ch <= r_ch + 1'b1;
      end
      if (w_we && w_last) audio_out <= w_out;
      if (!enable_in) begin
        r_ptr <= '0;
        r_filled <= 1'b0;
      end else if (r_state == DONE) begin
        r_ptr <= r_ptr >= w_lm1 ? '0 : r_ptr + 1'b1;
        if (r_ptr >= w_lm1) r_filled <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_echo_mc.sv
// tb_echo_mc: scoreboard bench for echo_mc (NBITS=16, NCHAN=2, depth 8, divider 8)
module tb_echo_mc;
  localparam int NC = 2;
  localparam int DM = 8;
  logic clk = 1'b0, srst = 1'b1, enable_in = 1'b0, mode_in = 1'b0;
  logic [15:0] delay_in = '0, decay_in = '0;
  logic [31:0] audio_in = '0;
  logic [31:0] audio_out;
  logic tick_out, valid_out;
  int total = 0, bad = 0;
  logic [31:0] sbq[$];
  int fidx = 0;
  logic signed [15:0] hx [NC][64];
  logic signed [15:0] hy [NC][64];

  echo_mc #(.NBITS(16), .NCHAN(NC), .DELAY_MAX_LENGTH(DM), .CLOCK_DIVIDER(8)) dut (
    .clk(clk), .srst(srst), .enable_in(enable_in), .mode_in(mode_in), .delay_in(delay_in),
    .decay_in(decay_in), .audio_in(audio_in), .audio_out(audio_out), .tick_out(tick_out), .valid_out(valid_out));

  always #5 clk = ~clk;

  // frame-level reference: y[n] = x[n] + floor(decay * src[n-L] / 2^15) once n >= L
  function automatic logic [15:0] model_y(input int c, input logic signed [15:0] x);
    int dl, l, e, s, src;
    dl = int'(delay_in);
    l = (dl > DM - 1 ? DM - 1 : dl) + 1;
    e = 0;
    if (fidx >= l) begin
      src = mode_in ? int'(hx[c][fidx-l]) : int'(hy[c][fidx-l]);
      e = (int'($signed(decay_in)) * src) >>> 15;
    end
    s = int'(x) + e;
`ifdef ECHO_MC_SATURATE_EN
    s = s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
`endif
    return s[15:0];
  endfunction

  task automatic do_frame(input logic [15:0] x0, input logic [15:0] x1, output logic [31:0] got,
                          output logic [31:0] exp_v, output int tw, output int lat);
    logic [15:0] y0, y1;
    audio_in = {x1, x0};
    y0 = model_y(0, x0);
    y1 = model_y(1, x1);
    hx[0][fidx] = x0; hx[1][fidx] = x1; hy[0][fidx] = y0; hy[1][fidx] = y1;
    fidx++;
    sbq.push_back({y1, y0});
    tw = 0;
    while (!tick_out && tw < 40) begin @(negedge clk); tw++; end
    lat = 0;
    if (tick_out) do begin @(negedge clk); lat++; end while (!valid_out && lat < 40);
    got = audio_out;
    exp_v = sbq.pop_front();
    if (!valid_out) begin
      total++; bad++;
      $display("FAIL frame_timeout: valid_out=%b after tick wait %0d lat %0d, want 1", valid_out, tw, lat);
    end
  endtask

  task automatic reset_dut;
    enable_in = 1'b1;
    srst = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    fidx = 0;
    sbq.delete();
  endtask

  task automatic test_reset;
    logic [31:0] got, ev;
    logic [15:0] x0, x1;
    int tw, lat;
    enable_in = 1'b1;
    srst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      audio_in = $urandom; delay_in = 16'($urandom); decay_in = 16'($urandom); mode_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if ({audio_out, tick_out, valid_out} !== 34'h0) begin
        bad++; $display("FAIL reset_state%0d: out=%h tick=%b valid=%b, want 0", i, audio_out, tick_out, valid_out);
      end
    end
    mode_in = 1'b0; delay_in = 16'd3; decay_in = 16'h4000;
    srst = 1'b0; fidx = 0; sbq.delete();
    x0 = 16'($urandom); x1 = 16'($urandom);
    do_frame(x0, x1, got, ev, tw, lat);
    total++; if (tw !== 1) begin bad++; $display("FAIL first_tick: %0d cycles, want 1", tw); end
    total++; if (lat !== 5) begin bad++; $display("FAIL first_latency: %0d cycles, want 5", lat); end
    total++; if (got !== ev) begin bad++; $display("FAIL reset_frame0: got %h want %h", got, ev); end
    total++; if (got !== {x1, x0}) begin bad++; $display("FAIL reset_passthru: got %h want %h", got, {x1, x0}); end
    do_frame(16'h1111, 16'h2222, got, ev, tw, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL second_latency: %0d cycles, want 5", lat); end
  endtask

  task automatic test_feedback;
    logic [31:0] got, ev;
    logic [15:0] want;
    int tw, lat;
    mode_in = 1'b0; delay_in = 16'd3; decay_in = 16'h4000;
    reset_dut();
    for (int f = 0; f < 11; f++) begin
      do_frame(f == 0 ? 16'h4000 : 16'h0000, 16'h0000, got, ev, tw, lat);
      want = f == 0 ? 16'h4000 : f == 4 ? 16'h2000 : f == 8 ? 16'h1000 : 16'h0000;
      total++; if (got !== ev) begin bad++; $display("FAIL fb_frame%0d: got %h want %h", f, got, ev); end
      total++; if (got !== {16'h0000, want}) begin bad++; $display("FAIL fb_table%0d: got %h want %h", f, got, {16'h0000, want}); end
    end
  endtask

  task automatic test_feedforward;
    logic [31:0] got, ev;
    logic [15:0] want;
    int tw, lat;
    mode_in = 1'b1; delay_in = 16'd3; decay_in = 16'h4000;
    reset_dut();
    for (int f = 0; f < 11; f++) begin
      do_frame(f == 0 ? 16'h4000 : 16'h0000, 16'h0000, got, ev, tw, lat);
      want = f == 0 ? 16'h4000 : f == 4 ? 16'h2000 : 16'h0000;
      total++; if (got !== ev) begin bad++; $display("FAIL ff_frame%0d: got %h want %h", f, got, ev); end
      total++; if (got !== {16'h0000, want}) begin bad++; $display("FAIL ff_table%0d: got %h want %h", f, got, {16'h0000, want}); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] got, ev;
    logic [15:0] want;
    int tw, lat;
    mode_in = 1'b0; delay_in = 16'd0; decay_in = 16'h7FFF;
    reset_dut();
    for (int f = 0; f < 4; f++) begin
      do_frame(16'h7000, 16'h0000, got, ev, tw, lat);
      total++; if (got !== ev) begin bad++; $display("FAIL ovf_frame%0d: got %h want %h", f, got, ev); end
`ifdef ECHO_MC_SATURATE_EN
      want = f == 0 ? 16'h7000 : 16'h7FFF;
`else
      want = f == 0 ? 16'h7000 : 16'hDFFF;
`endif
      if (f < 2) begin
        total++; if (got[15:0] !== want) begin bad++; $display("FAIL ovf_table%0d: got %h want %h", f, got[15:0], want); end
      end
    end
  endtask

  task automatic test_clamp;
    logic [31:0] got, ev;
    logic [15:0] want;
    int tw, lat;
    mode_in = 1'b1; delay_in = 16'hFFFF; decay_in = 16'h4000;
    reset_dut();
    for (int f = 0; f < 13; f++) begin
      do_frame(16'h0000, f == 0 ? 16'h4000 : 16'h0000, got, ev, tw, lat);
      want = f == 0 ? 16'h4000 : f == 8 ? 16'h2000 : 16'h0000;
      total++; if (got !== ev) begin bad++; $display("FAIL clamp_frame%0d: got %h want %h", f, got, ev); end
      total++; if (got !== {want, 16'h0000}) begin bad++; $display("FAIL clamp_table%0d: got %h want %h", f, got, {want, 16'h0000}); end
    end
  endtask

  task automatic test_enable_drop;
    logic [31:0] got, ev, held;
    int tw, lat, n, vcnt;
    mode_in = 1'b0; delay_in = 16'd2; decay_in = 16'h4000;
    reset_dut();
    do_frame(16'h1234, 16'h0042, got, ev, tw, lat);
    do_frame(16'h0100, 16'h0200, held, ev, tw, lat);
    total++; if (held !== ev) begin bad++; $display("FAIL drop_pre: got %h want %h", held, ev); end
    audio_in = 32'h5555_AAAA;
    n = 0;
    while (!tick_out && n < 40) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    enable_in = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (valid_out) vcnt++; end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL drop_valid: %0d pulses, want 0", vcnt); end
    total++; if (audio_out !== held) begin bad++; $display("FAIL drop_hold: got %h want %h", audio_out, held); end
    enable_in = 1'b1;
    fidx = 0;
    sbq.delete();
    for (int f = 0; f < 7; f++) begin
      do_frame(f == 0 ? 16'h4000 : 16'h0000, 16'h0000, got, ev, tw, lat);
      if (f == 0) begin
        total++; if (tw !== 1) begin bad++; $display("FAIL reenable_tick: %0d cycles, want 1", tw); end
      end
      total++; if (got !== ev) begin bad++; $display("FAIL reen_frame%0d: got %h want %h", f, got, ev); end
      total++;
      if (got[15:0] !== (f == 0 ? 16'h4000 : f == 3 ? 16'h2000 : f == 6 ? 16'h1000 : 16'h0000)) begin
        bad++; $display("FAIL reen_table%0d: got %h", f, got[15:0]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] got, ev;
    int tw, lat;
    for (int r = 0; r < 3; r++) begin
      mode_in = 1'($urandom_range(0, 1));
      delay_in = 16'($urandom_range(0, 10));
      decay_in = 16'($urandom);
      reset_dut();
      for (int f = 0; f < 16; f++) begin
        do_frame(16'($urandom), 16'($urandom), got, ev, tw, lat);
        total++; if (got !== ev) begin bad++; $display("FAIL rnd%0d_frame%0d: got %h want %h", r, f, got, ev); end
        total++; if (lat !== 5) begin bad++; $display("FAIL rnd%0d_lat%0d: %0d cycles, want 5", r, f, lat); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_feedback();
    test_feedforward();
    test_overflow();
    test_clamp();
    test_enable_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
